// File: rtl/cmp_window_stats_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmp_window_stats_if : sample/flag inputs and window-result outputs of
//                       cmp_window_stats.   Rev 1.0
// ---------------------------------------------------------------------------
interface cmp_window_stats_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic             in_valid;
  logic             a_lt_b;
  logic             a_eq_b;
  logic             a_gt_b;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] bad_cnt;
  logic [1:0]       verdict;

  modport master (
    output start, in_valid, a_lt_b, a_eq_b, a_gt_b,
    input  busy, done, lt_cnt, eq_cnt, gt_cnt, bad_cnt, verdict
  );

  modport slave (
    input  start, in_valid, a_lt_b, a_eq_b, a_gt_b,
    output busy, done, lt_cnt, eq_cnt, gt_cnt, bad_cnt, verdict
  );
endinterface
`default_nettype wire

// File: rtl/cmp_window_stats.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmp_window_stats : counts comparator flag outcomes over WIN_LEN valid
//                    samples and reports counts plus a majority verdict.
//                    Rev 1.0
// ---------------------------------------------------------------------------
module cmp_window_stats #(
  parameter int WIN_LEN = 16,
  parameter int CNT_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  cmp_window_stats_if.slave   bus
);

  localparam logic [CNT_W-1:0] c_WIN = CNT_W'(WIN_LEN);
  localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACC    = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CNT_W-1:0] r_lt,  r_eq,  r_gt,  r_bad,  r_smp;
  logic [CNT_W-1:0] w_lt,  w_eq,  w_gt,  w_bad,  w_smp;
  logic             w_last;

  logic [CNT_W-1:0] r_lt_cnt, r_eq_cnt, r_gt_cnt, r_bad_cnt;
  logic [1:0]       r_verdict;
  logic [1:0]       w_verdict;

  // A count wins only when it strictly exceeds both others; all-zero ties too.
  function automatic logic [1:0] f_verdict(
    input logic [CNT_W-1:0] lt,
    input logic [CNT_W-1:0] eq,
    input logic [CNT_W-1:0] gt
  );
    logic [1:0] v;
    v = 2'b11;
    if ((lt > eq) && (lt > gt))      v = 2'b00;
    else if ((eq > lt) && (eq > gt)) v = 2'b01;
    else if ((gt > lt) && (gt > eq)) v = 2'b10;
    return v;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_lt        = r_lt;
    w_eq        = r_eq;
    w_gt        = r_gt;
    w_bad       = r_bad;
    w_smp       = r_smp;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_lt        = '0;
          w_eq        = '0;
          w_gt        = '0;
          w_bad       = '0;
          w_smp       = '0;
          w_state_nxt = S_ACC;
        end
      end
      S_ACC: begin
        if (bus.in_valid) begin
          w_smp = r_smp + c_ONE;
          case ({bus.a_lt_b, bus.a_eq_b, bus.a_gt_b})
            3'b100:  w_lt  = r_lt  + c_ONE;
            3'b010:  w_eq  = r_eq  + c_ONE;
            3'b001:  w_gt  = r_gt  + c_ONE;
            default: w_bad = r_bad + c_ONE;
          endcase
          if (w_smp == c_WIN) begin
            w_last      = 1'b1;
            w_state_nxt = S_REPORT;
          end
        end
      end
      S_REPORT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_verdict = f_verdict(w_lt, w_eq, w_gt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lt    <= '0;
      r_eq    <= '0;
      r_gt    <= '0;
      r_bad   <= '0;
      r_smp   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lt    <= w_lt;
      r_eq    <= w_eq;
      r_gt    <= w_gt;
      r_bad   <= w_bad;
      r_smp   <= w_smp;
    end
  end

  // Results load on the edge that accepts the final sample, so they appear with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lt_cnt  <= '0;
      r_eq_cnt  <= '0;
      r_gt_cnt  <= '0;
      r_bad_cnt <= '0;
      r_verdict <= 2'b00;
    end else if (w_last) begin
      r_lt_cnt  <= w_lt;
      r_eq_cnt  <= w_eq;
      r_gt_cnt  <= w_gt;
      r_bad_cnt <= w_bad;
      r_verdict <= w_verdict;
    end
  end

  assign bus.busy    = (r_state == S_ACC);
  assign bus.done    = (r_state == S_REPORT);
  assign bus.lt_cnt  = r_lt_cnt;
  assign bus.eq_cnt  = r_eq_cnt;
  assign bus.gt_cnt  = r_gt_cnt;
  assign bus.bad_cnt = r_bad_cnt;
  assign bus.verdict = r_verdict;

endmodule
`default_nettype wire

// File: tb/tb_cmp_window_stats.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cmp_window_stats : self-checking bench for cmp_window_stats.   Rev 1.0
// ---------------------------------------------------------------------------
module tb_cmp_window_stats;

  localparam int WIN = 16;
  localparam int CW  = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cmp_window_stats_if #(.CNT_W(CW)) bus ();

  cmp_window_stats #(.WIN_LEN(WIN), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int p_lt = 0, p_eq = 0, p_gt = 0, p_bad = 0, p_v = 0;
  logic [2:0] samp_q[$];

  typedef struct {
    int         n_lt, n_eq, n_gt, n_bad;
    logic [2:0] bad_f;
    int         gaps;
    int         mid_start;
    logic       idle_v;
    logic       rep_start;
    int         e_lt, e_eq, e_gt, e_bad, e_v;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_lt"},  32'(bus.lt_cnt),  p_lt);
    chk({tag, "_eq"},  32'(bus.eq_cnt),  p_eq);
    chk({tag, "_gt"},  32'(bus.gt_cnt),  p_gt);
    chk({tag, "_bad"}, 32'(bus.bad_cnt), p_bad);
    chk({tag, "_v"},   32'(bus.verdict), p_v);
  endtask

  task automatic drive(input logic s, input logic v, input logic [2:0] f);
    bus.start    = s;
    bus.in_valid = v;
    {bus.a_lt_b, bus.a_eq_b, bus.a_gt_b} = f;
    @(posedge clk);
    #1;
  endtask

  // Plain reference: strict maximum wins, otherwise 3.
  function automatic int model_verdict(input int lt, input int eq, input int gt);
    int m, n, idx;
    int c[3];
    c[0] = lt; c[1] = eq; c[2] = gt;
    m = 0; n = 0; idx = 3;
    for (int k = 0; k < 3; k++) if (c[k] > m) m = c[k];
    for (int k = 0; k < 3; k++) if (c[k] == m) begin n++; idx = k; end
    if (m == 0 || n != 1) return 3;
    return idx;
  endfunction

  task automatic run_window(input logic idle_v, input int gaps, input int mid_start,
                            input logic rep_start,
                            input int e_lt, input int e_eq, input int e_gt,
                            input int e_bad, input int e_v);
    int sz;
    sz = samp_q.size();
    drive(1'b1, idle_v, 3'b100);
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_done", 32'(bus.done), 0);
    for (int i = 0; i < sz; i++) begin
      if (i > 0 && i <= 2 * gaps && (i % 2) == 0) begin
        drive(1'b0, 1'b0, 3'($urandom));
        chk("gap_busy", 32'(bus.busy), 1);
        chk("gap_done", 32'(bus.done), 0);
      end
      drive(i == mid_start, 1'b1, samp_q[i]);
      if (i < sz - 1) begin
        chk("acc_busy", 32'(bus.busy), 1);
        chk("acc_done", 32'(bus.done), 0);
        chk_held("acc_hold");
      end else begin
        chk("rep_done", 32'(bus.done), 1);
        chk("rep_busy", 32'(bus.busy), 0);
        p_lt = e_lt; p_eq = e_eq; p_gt = e_gt; p_bad = e_bad; p_v = e_v;
        chk_held("result");
        chk("sum", 32'(bus.lt_cnt) + 32'(bus.eq_cnt) + 32'(bus.gt_cnt) + 32'(bus.bad_cnt), WIN);
      end
    end
    drive(rep_start, 1'b1, 3'b010);
    chk("post_busy", 32'(bus.busy), 0);
    chk("post_done", 32'(bus.done), 0);
    chk_held("post_hold");
  endtask

  task automatic build(input int nl, input int ne, input int ng, input int nb, input logic [2:0] bf);
    samp_q.delete();
    for (int k = 0; k < nl; k++) samp_q.push_back(3'b100);
    for (int k = 0; k < ne; k++) samp_q.push_back(3'b010);
    for (int k = 0; k < ng; k++) samp_q.push_back(3'b001);
    for (int k = 0; k < nb; k++) samp_q.push_back(bf);
  endtask

  initial begin
    tbl[0] = '{0, 0, 16, 0,  3'b000, 5, -1, 1'b0, 1'b0, 0, 0, 16, 0,  2};
    tbl[1] = '{7, 6, 2,  1,  3'b110, 0, 8,  1'b0, 1'b1, 7, 6, 2,  1,  0};
    tbl[2] = '{5, 5, 5,  1,  3'b000, 2, -1, 1'b1, 1'b0, 5, 5, 5,  1,  3};
    tbl[3] = '{8, 0, 8,  0,  3'b000, 0, -1, 1'b0, 1'b0, 8, 0, 8,  0,  3};
    tbl[4] = '{0, 0, 0,  16, 3'b111, 0, -1, 1'b0, 1'b0, 0, 0, 0,  16, 3};
    tbl[5] = '{1, 0, 0,  15, 3'b101, 0, -1, 1'b0, 1'b1, 1, 0, 0,  15, 0};
    tbl[6] = '{0, 16, 0, 0,  3'b000, 3, 4,  1'b1, 1'b0, 0, 16, 0, 0,  1};

    bus.start = 1'b0; bus.in_valid = 1'b0;
    bus.a_lt_b = 1'b0; bus.a_eq_b = 1'b0; bus.a_gt_b = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk_held("rst");
    @(negedge clk) rst_n = 1'b1;

    // Valid samples without start must be ignored.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 3'b001 << (k % 3));
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_done", 32'(bus.done), 0);
      chk_held("idle");
    end

    for (int t = 0; t < 7; t++) begin
      build(tbl[t].n_lt, tbl[t].n_eq, tbl[t].n_gt, tbl[t].n_bad, tbl[t].bad_f);
      run_window(tbl[t].idle_v, tbl[t].gaps, tbl[t].mid_start, tbl[t].rep_start,
                 tbl[t].e_lt, tbl[t].e_eq, tbl[t].e_gt, tbl[t].e_bad, tbl[t].e_v);
    end

    // Asynchronous reset in the middle of a window.
    drive(1'b1, 1'b0, 3'b000);
    for (int k = 0; k < 9; k++) drive(1'b0, 1'b1, 3'b100);
    chk("pre_rst_busy", 32'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    p_lt = 0; p_eq = 0; p_gt = 0; p_bad = 0; p_v = 0;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk_held("mid_rst");
    @(negedge clk) rst_n = 1'b1;
    drive(1'b0, 1'b0, 3'b000);
    chk("after_rst_done", 32'(bus.done), 0);
    build(0, 16, 0, 0, 3'b000);
    run_window(1'b0, 0, -1, 1'b0, 0, 16, 0, 0, 1);

    // Random windows against the counting model.
    for (int w = 0; w < 100; w++) begin
      int ml, me, mg, mb;
      logic [2:0] f;
      ml = 0; me = 0; mg = 0; mb = 0;
      samp_q.delete();
      for (int k = 0; k < WIN; k++) begin
        if ($urandom_range(0, 9) < 7) begin
          f = 3'b001 << $urandom_range(0, 2);
        end else begin
          case ($urandom_range(0, 4))
            0:       f = 3'b000;
            1:       f = 3'b011;
            2:       f = 3'b101;
            3:       f = 3'b110;
            default: f = 3'b111;
          endcase
        end
        samp_q.push_back(f);
        if (f == 3'b100)      ml++;
        else if (f == 3'b010) me++;
        else if (f == 3'b001) mg++;
        else                  mb++;
      end
      run_window(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, WIN - 2)) : -1,
                 1'($urandom_range(0, 1)),
                 ml, me, mg, mb, model_verdict(ml, me, mg));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
